// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a fixed-latency data memory
module dmem_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_LIMIT = 1024,
    parameter int MEM_LAT    = 2,
    localparam int ADDR_W    = (ADDR_LIMIT > 1) ? $clog2(ADDR_LIMIT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [63:0]       r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [63:0]       r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int          CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [63:0] LIMIT = 64'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Arbitration candidate: a lone requester wins, a tie goes to the port not granted last.
    logic                pick_valid;
    logic                pick;
    logic                sel_we;
    logic [63:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_err;

    // Winner selection and address range check for the requester being sampled this edge
    always_comb begin
        pick_valid = r0_req | r1_req;
        pick       = (r0_req && r1_req) ? ~last_gnt_q : r1_req;
        sel_we     = pick ? r1_we    : r0_we;
        sel_addr   = pick ? r1_addr  : r0_addr;
        sel_wdata  = pick ? r1_wdata : r0_wdata;
        sel_err    = (sel_addr >= LIMIT);
    end

    // Next-state logic; DONE also samples requests so back-to-back grants lose no cycle
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        port_d     = port_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (pick_valid) begin
                    last_gnt_d = pick;
                    port_d     = pick;
                    we_d       = sel_we;
                    err_d      = sel_err;
                    addr_d     = sel_addr[ADDR_W-1:0];
                    wdata_d    = sel_wdata;
                    state_d    = sel_err ? S_DONE : S_ACCESS;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ACCESS: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latch registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            port_q     <= port_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    logic              in_access;
    logic              in_done;
    logic              gnt_any;
    logic [DATA_W-1:0] rdata_out;

    // Output decode; every bus is forced to zero outside the cycle it is meaningful
    always_comb begin
        in_access = (state_q == S_ACCESS);
        in_done   = (state_q == S_DONE);
        gnt_any   = in_access | (in_done & err_q);
        rdata_out = (in_done && !err_q && !we_q) ? rdata_q : '0;

        r0_gnt    = gnt_any & ~port_q;
        r1_gnt    = gnt_any &  port_q;
        r0_done   = in_done & ~port_q;
        r1_done   = in_done &  port_q;
        r0_err    = in_done & err_q & ~port_q;
        r1_err    = in_done & err_q &  port_q;
        r0_rdata  = port_q ? '0 : rdata_out;
        r1_rdata  = port_q ? rdata_out : '0;

        mem_en    = in_access;
        mem_we    = in_access & we_q;
        mem_addr  = in_access ? addr_q  : '0;
        mem_wdata = in_access ? wdata_q : '0;
        busy      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;

    // main instance, MEM_LAT = 2
    logic        r0_req, r0_we, r0_gnt, r0_done, r0_err;
    logic [63:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_done, r1_err;
    logic [63:0] r1_addr, r1_wdata, r1_rdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    // MEM_LAT = 1 instance (port 0 only)
    logic        a_req, a_gnt, a_done, a_err, a_r1_gnt, a_r1_done, a_r1_err;
    logic [63:0] a_addr, a_rdata, a_r1_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [9:0]  a_mem_addr;
    logic [63:0] a_mem_wdata, a_mem_rdata;

    // MEM_LAT = 4 instance (port 0 only)
    logic        b_req, b_gnt, b_done, b_err, b_r1_gnt, b_r1_done, b_r1_err;
    logic [63:0] b_addr, b_rdata, b_r1_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [9:0]  b_mem_addr;
    logic [63:0] b_mem_wdata, b_mem_rdata;

    int compared;
    int mismatched;
    int men_cnt;
    int mwe_cnt;
    int overlap;

    dmem_arbiter #(.DATA_W(64), .ADDR_LIMIT(1024), .MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.DATA_W(64), .ADDR_LIMIT(1024), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .r0_req(a_req), .r0_we(1'b0), .r0_addr(a_addr), .r0_wdata(64'd0),
        .r0_gnt(a_gnt), .r0_done(a_done), .r0_rdata(a_rdata), .r0_err(a_err),
        .r1_req(1'b0), .r1_we(1'b0), .r1_addr(64'd0), .r1_wdata(64'd0),
        .r1_gnt(a_r1_gnt), .r1_done(a_r1_done), .r1_rdata(a_r1_rdata), .r1_err(a_r1_err),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    dmem_arbiter #(.DATA_W(64), .ADDR_LIMIT(1024), .MEM_LAT(4)) u_lat4 (
        .clk(clk), .reset(reset),
        .r0_req(b_req), .r0_we(1'b0), .r0_addr(b_addr), .r0_wdata(64'd0),
        .r0_gnt(b_gnt), .r0_done(b_done), .r0_rdata(b_rdata), .r0_err(b_err),
        .r1_req(1'b0), .r1_we(1'b0), .r1_addr(64'd0), .r1_wdata(64'd0),
        .r1_gnt(b_r1_gnt), .r1_done(b_r1_done), .r1_rdata(b_r1_rdata), .r1_err(b_r1_err),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input logic [9:0] a);
        if (a == 10'd5) return 64'hAA;
        return 64'hA5A5_0000_0000_0000 | {54'd0, a};
    endfunction

    // main memory model: writes tracked in a side array, unwritten words read init_word
    logic [63:0] wmem [1024];
    bit          wvld [1024];
    logic [63:0] m_pipe0, m_pipe1;
    logic        m_v0, m_v1;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr] <= mem_wdata;
            wvld[mem_addr] <= 1'b1;
            mwe_cnt        <= mwe_cnt + 1;
        end
        if (mem_en) men_cnt <= men_cnt + 1;
        m_pipe0 <= wvld[mem_addr] ? wmem[mem_addr] : init_word(mem_addr);
        m_v0    <= mem_en && !mem_we;
        m_pipe1 <= m_pipe0;
        m_v1    <= m_v0;
    end
    assign mem_rdata = m_v1 ? m_pipe1 : 64'hDEAD_BEEF_DEAD_BEEF;

    logic [63:0] a_pipe;
    logic        a_v;
    logic [63:0] b_pipe [4];
    logic        b_v [4];
    always @(posedge clk) begin
        a_pipe    <= init_word(a_mem_addr);
        a_v       <= a_mem_en;
        b_pipe[0] <= init_word(b_mem_addr);
        b_v[0]    <= b_mem_en;
        for (int i = 1; i < 4; i++) begin
            b_pipe[i] <= b_pipe[i-1];
            b_v[i]    <= b_v[i-1];
        end
    end
    assign a_mem_rdata = a_v    ? a_pipe    : 64'hDEAD_BEEF_DEAD_BEEF;
    assign b_mem_rdata = b_v[3] ? b_pipe[3] : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(negedge clk) begin
        if ((r0_gnt && r1_gnt) || (r0_done && r1_done)) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // issue one request at a negedge (cycle 0) and record grant/done cycles
    task automatic do_req(input int p, input logic we, input logic [63:0] addr,
                          input logic [63:0] wd, output int gc, output int dc,
                          output logic [63:0] rd, output logic er,
                          output logic me, output logic [9:0] ma);
        gc = -1; dc = -1; rd = '0; er = 1'b0; me = 1'b0; ma = '0;
        if (p == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end
        for (int k = 1; k <= 20; k++) begin
            if (dc >= 0) break;
            @(negedge clk);
            if ((p == 0) ? r0_gnt : r1_gnt) begin
                gc = k; me = mem_en; ma = mem_addr;
                if (p == 0) r0_req = 1'b0; else r1_req = 1'b0;
            end
            if ((p == 0) ? r0_done : r1_done) begin
                dc = k;
                rd = (p == 0) ? r0_rdata : r1_rdata;
                er = (p == 0) ? r0_err : r1_err;
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    int          gc, dc;
    logic [63:0] rd;
    logic        er, me;
    logic [9:0]  ma;
    int          w0, e0;
    int          gseq [8];
    int          gcyc [8];
    int          ng;
    int          a_gc, a_dc, b_gc, b_dc;
    logic [63:0] a_rd, b_rd;

    initial begin
        reset = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        a_req = 0; a_addr = 0; b_req = 0; b_addr = 0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_flags", {55'd0, r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err,
                          mem_en, mem_we, busy}, 64'd0);
        chk("rst_buses", r0_rdata | r1_rdata | mem_wdata | {54'd0, mem_addr}, 64'd0);
        reset = 1'b0;

        // T1: r0 read addr 5
        do_req(0, 1'b0, 64'd5, 64'd0, gc, dc, rd, er, me, ma);
        chk("t1_gnt_cyc", 64'(gc), 64'd1);
        chk("t1_mem_en", {63'd0, me}, 64'd1);
        chk("t1_mem_addr", {54'd0, ma}, 64'd5);
        chk("t1_done_cyc", 64'(dc), 64'd4);
        chk("t1_rdata", rd, 64'hAA);
        chk("t1_err", {63'd0, er}, 64'd0);

        // T2: write 7 then read 7, back to back
        w0 = mwe_cnt;
        do_req(0, 1'b1, 64'd7, 64'h1234, gc, dc, rd, er, me, ma);
        chk("t2_wr_done_cyc", 64'(dc), 64'd4);
        chk("t2_wr_rdata", rd, 64'd0);
        do_req(0, 1'b0, 64'd7, 64'd0, gc, dc, rd, er, me, ma);
        chk("t2_b2b_gnt_cyc", 64'(gc), 64'd1);
        chk("t2_rd_rdata", rd, 64'h1234);
        chk("t2_we_count", 64'(mwe_cnt - w0), 64'd1);
        chk("t2_mem7", wmem[7], 64'h1234);

        // T4: illegal addresses on r1, then the last legal word
        e0 = men_cnt;
        do_req(1, 1'b0, 64'd1024, 64'd0, gc, dc, rd, er, me, ma);
        chk("t4_1024_gnt", 64'(gc), 64'd1);
        chk("t4_1024_done", 64'(dc), 64'd1);
        chk("t4_1024_err", {63'd0, er}, 64'd1);
        chk("t4_1024_rdata", rd, 64'd0);
        do_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_0000, 64'h55, gc, dc, rd, er, me, ma);
        chk("t4_big_done", 64'(dc), 64'd1);
        chk("t4_big_err", {63'd0, er}, 64'd1);
        chk("t4_no_mem_en", 64'(men_cnt - e0), 64'd0);
        do_req(1, 1'b0, 64'd1023, 64'd0, gc, dc, rd, er, me, ma);
        chk("t4_1023_done", 64'(dc), 64'd4);
        chk("t4_1023_err", {63'd0, er}, 64'd0);
        chk("t4_1023_rdata", rd, 64'hA5A5_0000_0000_03FF);

        // T3: both ports request continuously after reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ng = 0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd5;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'd1023;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (r0_gnt && ng < 8) begin gseq[ng] = 0; gcyc[ng] = k; ng++; end
            if (r1_gnt && ng < 8) begin gseq[ng] = 1; gcyc[ng] = k; ng++; end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        chk("t3_ngrants", 64'(ng), 64'd5);
        chk("t3_seq", {60'd0, 4'(gseq[0]), 4'(gseq[1]), 4'(gseq[2]), 4'(gseq[3])} & 64'hFFFF,
            64'h0101);
        chk("t3_cyc0", 64'(gcyc[0]), 64'd1);
        chk("t3_cyc1", 64'(gcyc[1]), 64'd5);
        for (int k = 0; k < 10; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("t3_drained", {63'd0, busy}, 64'd0);

        // T5: reset during WAIT
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd5;
        @(negedge clk);
        chk("t5_gnt", {63'd0, r0_gnt}, 64'd1);
        r0_req = 1'b0;
        @(negedge clk);
        chk("t5_busy_wait", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_flags", {55'd0, r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err,
                         mem_en, mem_we, busy}, 64'd0);
        chk("t5_buses", r0_rdata | r1_rdata | mem_wdata | {54'd0, mem_addr}, 64'd0);
        reset = 1'b0;
        do_req(0, 1'b0, 64'd5, 64'd0, gc, dc, rd, er, me, ma);
        chk("t5_after_done", 64'(dc), 64'd4);
        chk("t5_after_rdata", rd, 64'hAA);

        // T6: MEM_LAT = 1 and 4 builds in parallel
        a_gc = -1; a_dc = -1; b_gc = -1; b_dc = -1; a_rd = '0; b_rd = '0;
        a_req = 1'b1; a_addr = 64'd9;
        b_req = 1'b1; b_addr = 64'd300;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_gnt)  begin a_gc = k; a_req = 1'b0; end
            if (b_gnt)  begin b_gc = k; b_req = 1'b0; end
            if (a_done) begin a_dc = k; a_rd = a_rdata; end
            if (b_done) begin b_dc = k; b_rd = b_rdata; end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("t6_lat1_gnt", 64'(a_gc), 64'd1);
        chk("t6_lat1_done", 64'(a_dc), 64'd3);
        chk("t6_lat1_rdata", a_rd, 64'hA5A5_0000_0000_0009);
        chk("t6_lat4_gnt", 64'(b_gc), 64'd1);
        chk("t6_lat4_done", 64'(b_dc), 64'd6);
        chk("t6_lat4_rdata", b_rd, 64'hA5A5_0000_0000_012C);

        chk("no_overlap", 64'(overlap), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
